// File: rtl/mandel_pkg.sv
// Shared constants, state encoding and colour map for the Mandelbrot pixel engine.
package mandel_pkg;

  localparam int FX_WIDTH   = 18;
  localparam int FX_FRAC    = 13;
  localparam int PROD_WIDTH = 2 * FX_WIDTH + 1;

  // 4.0 at product scale (2*FX_FRAC fraction bits), one guard bit for |z|^2 sums.
  localparam logic [PROD_WIDTH-1:0] ESCAPE_R2 =
    {{(PROD_WIDTH - 2 * FX_FRAC - 3){1'b0}}, 3'b100, {(2 * FX_FRAC){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_ITER,
    ST_WRITE,
    ST_DONE
  } state_e;

  function automatic logic [11:0] colour_map(input logic [7:0] n);
    return {n[3:0], n[5:2], n[7:4]};
  endfunction

endpackage

// File: rtl/mandel_iter_step.sv
// One combinational z <- z^2 + c step in Q4.13, plus the |z|^2 > 4 escape test.
module mandel_iter_step
  import mandel_pkg::*;
(
  input  logic signed [FX_WIDTH-1:0] z_r,
  input  logic signed [FX_WIDTH-1:0] z_i,
  input  logic signed [FX_WIDTH-1:0] c_r,
  input  logic signed [FX_WIDTH-1:0] c_i,
  output logic signed [FX_WIDTH-1:0] z_r_next,
  output logic signed [FX_WIDTH-1:0] z_i_next,
  output logic                       escape
);

  logic signed [2*FX_WIDTH-1:0] rr, ii, ri;
  logic signed [PROD_WIDTH-1:0] diff, twice_ri, diff_sh, twice_sh;
  logic        [PROD_WIDTH-1:0] mag2;

  assign rr = z_r * z_r;
  assign ii = z_i * z_i;
  assign ri = z_r * z_i;

  assign mag2   = rr + ii;
  assign escape = mag2 > ESCAPE_R2;

  assign diff     = rr - ii;
  assign twice_ri = $signed({ri, 1'b0});
  assign diff_sh  = diff >>> FX_FRAC;
  assign twice_sh = twice_ri >>> FX_FRAC;

  // Truncation to FX_WIDTH wraps on overflow; no saturation is intended.
  assign z_r_next = diff_sh[FX_WIDTH-1:0] + c_r;
  assign z_i_next = twice_sh[FX_WIDTH-1:0] + c_i;

endmodule

// File: rtl/mandel_pixel_engine.sv
// Raster-order escape-time Mandelbrot generator writing 12-bit colours to frame-buffer port A.
module mandel_pixel_engine
  import mandel_pkg::*;
#(
  parameter int H_RES      = 320,
  parameter int V_RES      = 240,
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 12,
  parameter int MAX_ITER   = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_enable,
  input  logic                         i_start,
  input  logic signed [FX_WIDTH-1:0]   i_x0,
  input  logic signed [FX_WIDTH-1:0]   i_y0,
  input  logic        [FX_WIDTH-1:0]   i_step,
  output logic        [ADDR_WIDTH-1:0] o_addr,
  output logic        [DATA_WIDTH-1:0] o_data,
  output logic                         o_write,
  output logic                         o_busy,
  output logic                         o_done
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
  localparam logic [7:0]    N_MAX  = 8'(MAX_ITER);

  state_e state, state_next;

  logic        [XW-1:0]       x;
  logic        [YW-1:0]       y;
  logic signed [FX_WIDTH-1:0] x0_q, c_r, c_i, z_r, z_i, z_r_nx, z_i_nx;
  logic        [FX_WIDTH-1:0] step_q;
  logic        [7:0]          n;
  logic                       escape, iter_end, last_px;

  mandel_iter_step u_iter_step (
    .z_r      (z_r),
    .z_i      (z_i),
    .c_r      (c_r),
    .c_i      (c_i),
    .z_r_next (z_r_nx),
    .z_i_next (z_i_nx),
    .escape   (escape)
  );

  assign iter_end = escape || (n == N_MAX);
  assign last_px  = (x == X_LAST) && (y == Y_LAST);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (i_start) state_next = ST_INIT;
      ST_INIT:  if (i_enable) state_next = ST_ITER;
      ST_ITER:  if (i_enable && iter_end) state_next = ST_WRITE;
      ST_WRITE: state_next = last_px ? ST_DONE : ST_INIT;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // NOTE: datapath registers are few and cheap, so all are reset for clean X-free sim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x       <= '0;
      y       <= '0;
      x0_q    <= '0;
      step_q  <= '0;
      c_r     <= '0;
      c_i     <= '0;
      z_r     <= '0;
      z_i     <= '0;
      n       <= '0;
      o_addr  <= '0;
      o_data  <= '0;
      o_write <= 1'b0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: if (i_start) begin
          x0_q   <= i_x0;
          step_q <= i_step;
          c_r    <= i_x0;
          c_i    <= i_y0;
          x      <= '0;
          y      <= '0;
          o_addr <= '0;
          o_busy <= 1'b1;
        end
        ST_INIT: if (i_enable) begin
          z_r <= '0;
          z_i <= '0;
          n   <= '0;
        end
        ST_ITER: if (i_enable) begin
          if (iter_end) begin
            o_data  <= (n == N_MAX) ? '0 : DATA_WIDTH'(colour_map(n));
            o_write <= 1'b1;
          end else begin
            z_r <= z_r_nx;
            z_i <= z_i_nx;
            n   <= n + 8'd1;
          end
        end
        ST_WRITE: begin
          o_write <= 1'b0;
          o_addr  <= o_addr + ADDR_WIDTH'(1);
          if (x == X_LAST) begin
            x   <= '0;
            c_r <= x0_q;
            y   <= y + YW'(1);
            c_i <= c_i - step_q;
          end else begin
            x   <= x + XW'(1);
            c_r <= c_r + step_q;
          end
          if (last_px) begin
            o_done <= 1'b1;
            o_busy <= 1'b0;
          end
        end
        ST_DONE: o_done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mandel_pixel_engine.sv
// Scoreboard bench for mandel_pixel_engine on a reduced 8x4 frame with a reference iteration model.
module tb_mandel_pixel_engine;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam int MI = 255;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                i_enable = 1'b1;
  logic                i_start = 1'b0;
  logic signed [17:0]  i_x0 = '0;
  logic signed [17:0]  i_y0 = '0;
  logic        [17:0]  i_step = '0;
  logic [AW-1:0]       o_addr;
  logic [DW-1:0]       o_data;
  logic                o_write, o_busy, o_done;

  typedef struct {
    int addr;
    int data;
    int n;
    int mode;  // 0: no gap check, 1: exact gap, 2: enable 1-in-4 gap window
  } exp_t;

  exp_t   sb[$];
  exp_t   e;
  int     total = 0;
  int     bad = 0;
  int     done_cnt = 0;
  longint cyc = 0;
  longint last_wr = 0;
  longint gap;
  bit     gate = 1'b0;
  bit     prev_w = 1'b0;

  mandel_pixel_engine #(
    .H_RES(H), .V_RES(V), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_ITER(MI)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_enable (i_enable),
    .i_start  (i_start),
    .i_x0     (i_x0),
    .i_y0     (i_y0),
    .i_step   (i_step),
    .o_addr   (o_addr),
    .o_data   (o_data),
    .o_write  (o_write),
    .o_busy   (o_busy),
    .o_done   (o_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Enable driver: high on one edge in four when gating is on.
  initial begin
    int phase = 0;
    forever begin
      @(negedge clk);
      phase = (phase + 1) % 4;
      i_enable = gate ? (phase == 0) : 1'b1;
    end
  end

  function automatic int model_n(input logic signed [17:0] cr, input logic signed [17:0] ci);
    logic signed [17:0] zr, zi;
    longint rr, ii, ri, tr, ti;
    zr = '0;
    zi = '0;
    for (int n = 0; n < MI; n++) begin
      rr = longint'(zr) * longint'(zr);
      ii = longint'(zi) * longint'(zi);
      ri = longint'(zr) * longint'(zi);
      if (rr + ii > (longint'(1) << 28)) return n;
      tr = ((rr - ii) >>> 13) + longint'(cr);
      ti = ((2 * ri) >>> 13) + longint'(ci);
      zr = tr[17:0];
      zi = ti[17:0];
    end
    return MI;
  endfunction

  task automatic push_frame(input logic signed [17:0] x0, input logic signed [17:0] y0,
                            input logic [17:0] step, input int mode);
    longint t;
    logic signed [17:0] cr, ci;
    logic [7:0] nb;
    exp_t ex;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        t  = longint'(x0) + longint'(x) * longint'(step);
        cr = t[17:0];
        t  = longint'(y0) - longint'(y) * longint'(step);
        ci = t[17:0];
        ex.n    = model_n(cr, ci);
        nb      = ex.n[7:0];
        ex.addr = y * H + x;
        ex.data = (ex.n == MI) ? 0 : int'({nb[3:0], nb[5:2], nb[7:4]});
        ex.mode = mode;
        sb.push_back(ex);
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_frame(input logic signed [17:0] x0, input logic signed [17:0] y0,
                           input logic [17:0] step, input int mode, input bit pokes);
    bit finished;
    push_frame(x0, y0, step, mode);
    done_cnt = 0;
    @(negedge clk);
    i_x0    = x0;
    i_y0    = y0;
    i_step  = step;
    i_start = 1'b1;
    last_wr = cyc;
    @(negedge clk);
    i_start = 1'b0;
    check("busy_after_start", o_busy, 1);
    finished = 1'b0;
    for (int k = 0; k < 40000 && !finished; k++) begin
      @(negedge clk);
      if (pokes && (k % 40 == 30)) begin
        i_start = 1'b1;
        i_x0    = '0;
        i_y0    = '0;
        i_step  = 18'd999;
      end else begin
        i_start = 1'b0;
        i_x0    = x0;
        i_y0    = y0;
        i_step  = step;
      end
      if (done_cnt != 0) finished = 1'b1;
    end
    i_start = 1'b0;
    check("frame_finished", finished, 1);
    repeat (6) @(negedge clk);
    check("done_once", done_cnt, 1);
    check("sb_drained", sb.size(), 0);
    check("idle_not_busy", o_busy, 0);
    if (!finished) apply_reset();
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_write) begin
        check("write_one_clk", prev_w, 0);
        if (sb.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          e   = sb.pop_front();
          gap = cyc - last_wr;
          last_wr = cyc;
          check("addr", o_addr, e.addr);
          check("data", o_data, e.data);
          if (e.mode == 1) check("pixel_gap", gap, e.n + 3);
          else if (e.mode == 2)
            check("pixel_gap_gated", (gap >= 4 * e.n + 6) && (gap <= 4 * e.n + 9), 1);
        end
      end
      if (o_done) begin
        done_cnt++;
        check("done_busy_low", o_busy, 0);
        check("done_after_last", sb.size(), 0);
      end
      prev_w = o_write;
    end else begin
      prev_w = 1'b0;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_addr", o_addr, 0);
    check("rst_data", o_data, 0);
    check("rst_write", o_write, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Interior: every pixel runs to the cap, 258 clks apart, colour 0.
    run_frame(18'sd0, 18'sd0, 18'd0, 1, 1'b0);

    // Reset mid-ITER on the second pixel of an interior frame.
    push_frame(18'sd0, 18'sd0, 18'd0, 1);
    @(negedge clk);
    i_start = 1'b1;
    last_wr = cyc;
    @(negedge clk);
    i_start = 1'b0;
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_addr", o_addr, 0);
    check("abort_data", o_data, 0);
    check("abort_write", o_write, 0);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    sb.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_strobe", o_write, 0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_stays_idle", o_busy, 0);
    end

    // Fast escape: c = 2.0 gives n = 2, colour 12'h200, 5 clks per pixel.
    run_frame(18'sd16384, 18'sd0, 18'd0, 1, 1'b0);

    // Raster/step from (-2.0, 1.0) with step 1/64.
    run_frame(-18'sd16384, 18'sd8192, 18'd128, 1, 1'b0);

    // Mixed escape counts including interior points.
    run_frame(-18'sd6144, 18'sd2048, 18'd1024, 1, 1'b0);

    // Enable gated to one clk in four.
    gate = 1'b1;
    run_frame(18'sd16384, 18'sd0, 18'd0, 2, 1'b0);
    run_frame(-18'sd16384, 18'sd8192, 18'd128, 2, 1'b0);
    gate = 1'b0;
    repeat (4) @(negedge clk);

    // Start pulses and input changes while busy must be ignored.
    run_frame(18'sd16384, 18'sd0, 18'd0, 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
